// File: rtl/decoder_scan_sequencer_if.sv
// Handshake and select bundle between a scan controller and decoder_scan_sequencer.
// The stop signal exists only when SCAN_CONTINUOUS_EN is defined.
interface decoder_scan_sequencer_if;
  logic       start;
  logic       stall;
`ifdef SCAN_CONTINUOUS_EN
  logic       stop;
`endif
  logic       x;
  logic       y;
  logic       z;
  logic       w;
  logic       e;
  logic [3:0] idx;
  logic       busy;
  logic       done;

  modport master (
`ifdef SCAN_CONTINUOUS_EN
    output stop,
`endif
    output start, stall,
    input  x, y, z, w, e, idx, busy, done
  );

  modport slave (
`ifdef SCAN_CONTINUOUS_EN
    input  stop,
`endif
    input  start, stall,
    output x, y, z, w, e, idx, busy, done
  );
endinterface

// File: rtl/decoder_scan_sequencer.sv
// Drives the 4:16 decoder select/enable, strobing rows 0..LAST_IDX for DWELL cycles each.
// SCAN_CONTINUOUS_EN: wrap to row 0 after each pass until stop is requested.
//   state  | meaning
//   S_IDLE | waiting for start, e=0, idx=0
//   S_RUN  | scanning, busy=1, e=~stall (registered)
//   S_DONE | one-cycle done pulse, then back to S_IDLE
module decoder_scan_sequencer #(
  parameter int unsigned LAST_IDX = 15,
  parameter int unsigned DWELL    = 1
) (
  input logic                      clk,
  input logic                      rst,
  decoder_scan_sequencer_if.slave  bus
);

  localparam logic [3:0] LAST  = LAST_IDX[3:0];
  localparam logic [7:0] DW_M1 = 8'(DWELL - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       e_q, e_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       dwell_end;
  logic       at_last;
`ifdef SCAN_CONTINUOUS_EN
  logic       stop_q, stop_d;
  logic       stop_req;
  assign stop_req = stop_q | bus.stop;
`endif

  assign dwell_end = (cnt_q == DW_M1);
  assign at_last   = (idx_q == LAST);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    e_d     = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SCAN_CONTINUOUS_EN
    stop_d  = stop_q;
`endif
    case (state_q)
      S_IDLE: begin
        idx_d = 4'd0;
        cnt_d = 8'd0;
`ifdef SCAN_CONTINUOUS_EN
        stop_d = 1'b0;
`endif
        if (bus.start) begin
          state_d = S_RUN;
          e_d     = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        busy_d = 1'b1;
`ifdef SCAN_CONTINUOUS_EN
        stop_d = stop_req;
`endif
        // A stalled cycle freezes position and counter; e drops for the following cycle.
        if (!bus.stall) begin
          e_d = 1'b1;
          if (!dwell_end) begin
            cnt_d = cnt_q + 8'd1;
          end else begin
            cnt_d = 8'd0;
`ifdef SCAN_CONTINUOUS_EN
            if (stop_req) begin
              state_d = S_DONE;
              e_d     = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else if (at_last) begin
              idx_d  = 4'd0;
              done_d = 1'b1;
            end else begin
              idx_d = idx_q + 4'd1;
            end
`else
            if (at_last) begin
              state_d = S_DONE;
              e_d     = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 4'd1;
            end
`endif
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = 4'd0;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 4'd0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 8'd0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SCAN_CONTINUOUS_EN
      stop_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SCAN_CONTINUOUS_EN
      stop_q  <= stop_d;
`endif
    end
  end

  assign bus.idx  = idx_q;
  assign bus.x    = idx_q[3];
  assign bus.y    = idx_q[2];
  assign bus.z    = idx_q[1];
  assign bus.w    = idx_q[0];
  assign bus.e    = e_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (LAST_IDX <= 32'd15 && DWELL != 32'd0)
        else $error("decoder_scan_sequencer: LAST_IDX/DWELL out of range");
    end
  end
`endif

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench for decoder_scan_sequencer: three instances cover the
// LAST_IDX/DWELL combinations; SCAN_CONTINUOUS_EN adds a wrap/stop sequence.
module tb_decoder_scan_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  decoder_scan_sequencer_if if_a ();
  decoder_scan_sequencer_if if_b ();
  decoder_scan_sequencer_if if_c ();

  decoder_scan_sequencer #(.LAST_IDX(15), .DWELL(1)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  decoder_scan_sequencer #(.LAST_IDX(2),  .DWELL(3)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  decoder_scan_sequencer #(.LAST_IDX(3),  .DWELL(1)) u_c (.clk(clk), .rst(rst), .bus(if_c));

  // {x,y,z,w, idx, e, busy, done}
  logic [10:0] obs_a, obs_b, obs_c;
  assign obs_a = {if_a.x, if_a.y, if_a.z, if_a.w, if_a.idx, if_a.e, if_a.busy, if_a.done};
  assign obs_b = {if_b.x, if_b.y, if_b.z, if_b.w, if_b.idx, if_b.e, if_b.busy, if_b.done};
  assign obs_c = {if_c.x, if_c.y, if_c.z, if_c.w, if_c.idx, if_c.e, if_c.busy, if_c.done};

  function automatic logic [10:0] ex(int i, bit e, bit b, bit d);
    logic [3:0] v;
    v = 4'(i);
    return {v, v, e, b, d};
  endfunction

  task automatic chk(string tag, logic [10:0] obs, logic [10:0] exp);
    n_chk++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h (xyzw,idx,e,busy,done)", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    if_a.start = 1'b0; if_a.stall = 1'b0;
    if_b.start = 1'b0; if_b.stall = 1'b0;
    if_c.start = 1'b0; if_c.stall = 1'b0;
`ifdef SCAN_CONTINUOUS_EN
    if_a.stop = 1'b0; if_b.stop = 1'b0; if_c.stop = 1'b0;
`endif

    tick(); tick();
    chk("reset_a", obs_a, ex(0, 0, 0, 0));
    chk("reset_b", obs_b, ex(0, 0, 0, 0));
    chk("reset_c", obs_c, ex(0, 0, 0, 0));
    rst = 1'b0;
    tick();
    chk("idle_no_start", obs_a, ex(0, 0, 0, 0));

    // Full 16-row scan, one cycle per row
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("scan16_row%0d", i), obs_a, ex(i, 1, 1, 0));
      tick();
    end
    chk("scan16_done", obs_a, ex(15, 0, 0, 1));
    tick();
    chk("scan16_idle", obs_a, ex(0, 0, 0, 0));
    tick();
    chk("scan16_stay_idle", obs_a, ex(0, 0, 0, 0));

    // Three rows, three cycles each
    if_b.start = 1'b1;
    tick();
    if_b.start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("dwell3_step%0d", i), obs_b, ex(i / 3, 1, 1, 0));
      tick();
    end
    chk("dwell3_done", obs_b, ex(2, 0, 0, 1));
    tick();
    chk("dwell3_idle", obs_b, ex(0, 0, 0, 0));

    // Stall for two cycles while row 5 is shown
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_pre_row%0d", i), obs_a, ex(i, 1, 1, 0));
      tick();
    end
    chk("stall_row5_shown", obs_a, ex(5, 1, 1, 0));
    if_a.stall = 1'b1;
    tick();
    chk("stall_hold1", obs_a, ex(5, 0, 1, 0));
    tick();
    if_a.stall = 1'b0;
    chk("stall_hold2", obs_a, ex(5, 0, 1, 0));
    tick();
    for (int i = 6; i < 16; i++) begin
      chk($sformatf("stall_post_row%0d", i), obs_a, ex(i, 1, 1, 0));
      tick();
    end
    chk("stall_done", obs_a, ex(15, 0, 0, 1));
    tick();
    chk("stall_single_done", obs_a, ex(0, 0, 0, 0));

    // Reset in the middle of a scan
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("rst_at_row7", obs_a, ex(7, 1, 1, 0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_cleared", obs_a, ex(0, 0, 0, 0));
    tick();
    chk("rst_no_done", obs_a, ex(0, 0, 0, 0));
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("rescan_row%0d", i), obs_a, ex(i, 1, 1, 0));
      tick();
    end
    chk("rescan_done", obs_a, ex(15, 0, 0, 1));
    tick();

    // start held high: RUN x4, DONE, one IDLE, repeat (period 6)
    if_c.start = 1'b1;
    for (k = 1; k <= 40; k++) begin
      tick();
      case (k % 6)
        1, 2, 3, 4: chk($sformatf("held_k%0d", k), obs_c, ex((k % 6) - 1, 1, 1, 0));
        5:          chk($sformatf("held_k%0d", k), obs_c, ex(3, 0, 0, 1));
        default:    chk($sformatf("held_k%0d", k), obs_c, ex(0, 0, 0, 0));
      endcase
    end
    if_c.start = 1'b0;
    tick();
    chk("held_last_done", obs_c, ex(3, 0, 0, 1));
    tick();
    chk("held_release_idle", obs_c, ex(0, 0, 0, 0));
    tick();
    chk("held_stays_idle", obs_c, ex(0, 0, 0, 0));

`ifdef SCAN_CONTINUOUS_EN
    // Continuous passes with a done pulse on each wrap, then stop at row 1
    if_c.start = 1'b1;
    tick();
    if_c.start = 1'b0;
    for (k = 1; k <= 9; k++) begin
      chk($sformatf("cont_k%0d", k), obs_c,
          ex((k - 1) % 4, 1, 1, (k > 1 && ((k - 1) % 4) == 0)));
      tick();
    end
    chk("cont_row1", obs_c, ex(1, 1, 1, 0));
    if_c.stop = 1'b1;
    tick();
    if_c.stop = 1'b0;
    chk("cont_stop_done", obs_c, ex(1, 0, 0, 1));
    tick();
    chk("cont_stop_idle", obs_c, ex(0, 0, 0, 0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
- Sequential driver placed directly upstream of the 4:16 one-hot decoder (`decoder`).
- Produces the decoder's select bits (x = MSB, y, z, w = LSB) and enable `e`, so the decoder strobes one row line at a time.
- Used to sequence partial-product row strobes in the Dadda multiplier datapath.
- Scans indices 0..LAST_IDX and holds each index for DWELL cycles. Has a start/done handshake and a stall input.

Parameters:
- LAST_IDX, 15, final index of the scan; legal range 0..15.
- DWELL, 1, cycles each index is held with `e`=1; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a scan; sampled only in IDLE.
- stall  input  1  freeze scan position; forces `e`=0 while high in RUN.
- x  output  1  select bit 3 (MSB) to decoder.
- y  output  1  select bit 2.
- z  output  1  select bit 1.
- w  output  1  select bit 0 (LSB).
- e  output  1  decoder enable.
- idx  output  4  current index, equal to {x,y,z,w}.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the scan completes.

Behaviour:
- Clock and reset: one clock (`clk`). Reset is synchronous and active-high (`rst`); it has priority over all other inputs.
- Reset values: state=IDLE, idx=0, x=y=z=w=0, e=0, busy=0, done=0, dwell counter=0.
- All outputs are registered.
- States:
  - IDLE: e=0, busy=0, idx=0. If start=1, go to RUN next cycle with idx=0 and dwell counter=0.
  - RUN: busy=1, e = ~stall.
    - stall=1 freezes idx and the dwell counter.
    - stall=0: the dwell counter increments each cycle.
    - When the dwell counter reaches DWELL-1 and idx != LAST_IDX: idx increments and the dwell counter clears.
    - When the dwell counter reaches DWELL-1 and idx == LAST_IDX: go to DONE.
  - DONE: e=0, busy=0, done=1 for exactly one cycle. Next cycle: IDLE, idx=0.
- Cycle counts:
  - Latency from start sampled to first e=1: 1 cycle.
  - An unstalled scan holds e=1 for exactly (LAST_IDX+1)*DWELL consecutive cycles.
- Select bits always equal idx. Decoder output d[idx] is active exactly when e=1.
- Handshake and boundary cases:
  - start in RUN or DONE: ignored; not queued.
  - start held high continuously: a new scan begins the cycle after IDLE is re-entered, giving one IDLE cycle between scans.
  - stall asserted in the same cycle as a would-be advance: no advance. The advance occurs on the first unstalled cycle that completes the dwell.
  - LAST_IDX=0: single index 0, held DWELL cycles, then DONE.
  - DWELL=1: index advances every unstalled cycle.
  - idx never exceeds LAST_IDX; no wrap to 0 in RUN.
  - rst mid-RUN: next cycle IDLE with all outputs at reset values; no done pulse.
- Width rules:
  - Dwell counter is 8 bits.
  - Parameter values outside the legal ranges are unsupported. A simulation-only check flags LAST_IDX>15 or DWELL==0.

Optional Feature:
- Macro: SCAN_CONTINUOUS_EN.
- When defined:
  - Adds input port `stop` (1 bit).
  - In RUN, completion of LAST_IDX wraps idx to 0 and stays in RUN, asserting `done` for one cycle per completed pass (scan continues).
  - stop=1 sampled in RUN: finish the current index's dwell, then go to DONE regardless of idx (done pulse), then IDLE.
  - stop outside RUN is ignored.
- When undefined: no `stop` port; behaviour exactly as above (single pass then DONE).

Test Plan:
- Reset then single pulse on start, LAST_IDX=15, DWELL=1 -> e=1 for 16 cycles, idx=0..15 in order, done pulses one cycle after idx=15, busy low afterwards.
- DWELL=3, LAST_IDX=2, start pulse -> idx sequence 0,0,0,1,1,1,2,2,2 with e=1, then done=1, then IDLE.
- LAST_IDX=15, DWELL=1, stall high for 2 cycles while idx=5 -> e=0 during those cycles, idx held at 5, total scan 18 cycles, done still pulses once.
- rst asserted while idx=7 in RUN -> next cycle idx=0, e=0, busy=0, no done pulse; a subsequent start runs a full scan from 0.
- start held high for 40 cycles, LAST_IDX=3, DWELL=1 -> repeated scans 0..3, each followed by a done cycle and one IDLE cycle. Extra start pulses during RUN produce no extra scans.
- With SCAN_CONTINUOUS_EN, LAST_IDX=3 -> idx 0,1,2,3,0,1,… with a done pulse each wrap. stop asserted at idx=1 -> DONE after idx=1, then IDLE.
